// File: rtl/csi2_mux_sel_ctrl.sv
// Channel-select sequencer for the 4-to-1 CSI-2 lane mux: it moves the select only
// after the lanes have sat in LP-11 for a while, then holds off sel_valid_o until the new channel settles.
module csi2_mux_sel_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int IDLE_MIN   = 16,
    parameter int SETTLE_CYC = 32,
    parameter int FRM_CNT_W  = 8,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 lp_idle_i,
    input  logic                 frame_end_i,
    input  logic                 auto_en_i,
    input  logic [NUM_CH-1:0]    ch_mask_i,
    input  logic [FRM_CNT_W-1:0] frames_per_ch_i,
    input  logic                 req_valid_i,
    input  logic [SEL_W-1:0]     req_ch_i,
    output logic                 req_ready_o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 sel_valid_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int SEL_SPAN = 2 ** SEL_W;
    localparam int IDLE_W   = $clog2(IDLE_MIN + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_IDLE,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    state_t                state_q;
    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      target_q;
    logic                  sel_valid_q;
    logic                  busy_q;
    logic                  req_ready_q;
    logic                  err_q;
    logic [FRM_CNT_W-1:0]  frm_cnt_q;
    logic [IDLE_W-1:0]     idle_cnt_q;
    logic [SETTLE_W-1:0]   settle_cnt_q;

    // Mask and range tables padded to the full select span so any select code indexes safely.
    logic [SEL_SPAN-1:0]   mask_ext;
    logic [SEL_SPAN-1:0]   ch_in_range;

    for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_ch_tbl
        if (gi < NUM_CH) begin : g_real
            assign mask_ext[gi]    = ch_mask_i[gi];
            assign ch_in_range[gi] = 1'b1;
        end else begin : g_pad
            assign mask_ext[gi]    = 1'b0;
            assign ch_in_range[gi] = 1'b0;
        end
    end

    logic [FRM_CNT_W-1:0]  fpc_eff_d;
    logic                  frm_done_d;
    logic                  cur_masked_d;
    logic [SEL_W-1:0]      next_ch_d;
    logic                  next_found_d;
    logic [SEL_W-1:0]      cand_d;

    assign fpc_eff_d    = (frames_per_ch_i == '0) ? FRM_CNT_W'(1) : frames_per_ch_i;
    assign frm_done_d   = ({1'b0, frm_cnt_q} + (FRM_CNT_W+1)'(1)) >= {1'b0, fpc_eff_d};
    assign cur_masked_d = ~mask_ext[sel_q];

    // Next eligible channel strictly after the current one, wrapping; never the current one itself.
    always_comb begin
        next_ch_d    = sel_q;
        next_found_d = 1'b0;
        cand_d       = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            cand_d = SEL_W'((int'(sel_q) + i) % NUM_CH);
            if (!next_found_d && mask_ext[cand_d]) begin
                next_ch_d    = cand_d;
                next_found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_SETTLE;
            sel_q        <= '0;
            target_q     <= '0;
            sel_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
            req_ready_q  <= 1'b0;
            err_q        <= 1'b0;
            frm_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    req_ready_q <= ~auto_en_i;
                    if (auto_en_i && cur_masked_d) begin
                        err_q <= 1'b1;
                    end
                    if (req_valid_i && req_ready_q) begin
                        if (!ch_in_range[req_ch_i]) begin
                            err_q <= 1'b1;
                        end else if (req_ch_i != sel_q) begin
                            target_q    <= req_ch_i;
                            state_q     <= ST_WAIT_IDLE;
                            idle_cnt_q  <= '0;
                            sel_valid_q <= 1'b0;
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end else if (auto_en_i && frame_end_i) begin
                        // A masked-off current channel is abandoned at the first frame end.
                        if (frm_done_d || cur_masked_d) begin
                            frm_cnt_q <= '0;
                            if (next_found_d) begin
                                target_q    <= next_ch_d;
                                state_q     <= ST_WAIT_IDLE;
                                idle_cnt_q  <= '0;
                                sel_valid_q <= 1'b0;
                                req_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                        end else begin
                            frm_cnt_q <= frm_cnt_q + FRM_CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!lp_idle_i) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IDLE_W'(IDLE_MIN - 1)) begin
                        state_q <= ST_SWITCH;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                    end
                end
                ST_SWITCH: begin
                    sel_q        <= target_q;
                    settle_cnt_q <= '0;
                    state_q      <= ST_SETTLE;
                end
                default: begin
                    if (settle_cnt_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                        state_q     <= ST_RUN;
                        sel_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= ~auto_en_i;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
                    end
                end
            endcase
        end
    end

    assign sel_o       = sel_q;
    assign sel_valid_o = sel_valid_q;
    assign busy_o      = busy_q;
    assign req_ready_o = req_ready_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_csi2_mux_sel_ctrl.sv
// Bench for csi2_mux_sel_ctrl: stimulus queues the expected settled channel, and a
// monitor checks each rising sel_valid_o against it, including switch and settle latencies.
module tb_csi2_mux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lp_idle = 1'b1;
    logic       frame_end = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic [7:0] fpc = 8'd0;
    logic       req_valid = 1'b0;
    logic [1:0] req_ch = 2'd0;
    logic       req_ready_o;
    logic [1:0] sel_o;
    logic       sel_valid_o;
    logic       busy_o;
    logic       err_o;

    csi2_mux_sel_ctrl #(
        .NUM_CH(4), .IDLE_MIN(16), .SETTLE_CYC(32), .FRM_CNT_W(8)
    ) dut (
        .clk_i(clk), .reset_i(rst), .lp_idle_i(lp_idle), .frame_end_i(frame_end),
        .auto_en_i(auto_en), .ch_mask_i(ch_mask), .frames_per_ch_i(fpc),
        .req_valid_i(req_valid), .req_ch_i(req_ch), .req_ready_o(req_ready_o),
        .sel_o(sel_o), .sel_valid_o(sel_valid_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int trig;   // cycle of the triggering edge, -1 when the trigger is a reset release
        int lat;
        int err;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_err = 0;
    int   selchg_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency bookkeeping and scoreboard pop on every rising sel_valid_o.
    initial forever begin
        @(negedge rst);
        selchg_cyc = cyc;
    end

    initial begin
        logic [1:0] prev_sel;
        logic       prev_valid;
        exp_t       e;
        prev_sel   = 2'd0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sel_o != prev_sel) selchg_cyc = cyc;
                if (sel_valid_o && !prev_valid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_valid: got sel=%0d with no expected switch", sel_o);
                    end else begin
                        e = sb.pop_front();
                        check("sel", int'(sel_o), e.sel);
                        check("err", int'(err_o), e.err);
                        check("busy_at_valid", int'(busy_o), 0);
                        check("settle_lat", cyc - selchg_cyc, 32);
                        if (e.trig >= 0) check("switch_lat", selchg_cyc - e.trig, e.lat);
                        $display("[TB] txn: sel=%0d err=%0d settle=%0d switch=%0d", sel_o, err_o,
                                 cyc - selchg_cyc, (e.trig >= 0) ? selchg_cyc - e.trig : -1);
                    end
                end
            end
            prev_sel   = sel_o;
            prev_valid = rst ? 1'b0 : sel_valid_o;
        end
    end

    task automatic push_exp(input int sel, input int trig, input int lat);
        exp_t e;
        e.sel  = sel;
        e.trig = trig;
        e.lat  = lat;
        e.err  = exp_err;
        sb.push_back(e);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sel_valid_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL wait_valid: timeout, sel_valid_o=%0d required 1", sel_valid_o);
        end
    endtask

    // Issue one manual request in RUN; sw says whether a switch is expected.
    task automatic manual_req(input int ch, input bit sw, input bit push, input int lat);
        req_valid = 1'b1;
        req_ch    = 2'(ch);
        if (push) push_exp(ch, cyc + 1, lat);
        tick();
        req_valid = 1'b0;
        if (sw) begin
            check("rdy_drop", int'(req_ready_o), 0);
            check("valid_drop", int'(sel_valid_o), 0);
        end else begin
            check("same_ch_valid", int'(sel_valid_o), 1);
            check("same_ch_busy", int'(busy_o), 0);
        end
    endtask

    task automatic pulse_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    initial begin
        int seq[3];
        seq = '{1, 3, 0};

        // Reset state and release with lp_idle held high.
        repeat (3) tick();
        check("rst_sel", int'(sel_o), 0);
        check("rst_valid", int'(sel_valid_o), 0);
        check("rst_busy", int'(busy_o), 1);
        check("rst_ready", int'(req_ready_o), 0);
        check("rst_err", int'(err_o), 0);
        push_exp(0, -1, 0);
        rst = 1'b0;
        wait_valid();
        check("run_ready", int'(req_ready_o), 1);

        // Manual switch to ch2 with steady idle.
        manual_req(2, 1'b1, 1'b1, 17);
        wait_valid();

        // Manual switch to ch1 with idle broken after 10 counted cycles.
        manual_req(1, 1'b1, 1'b1, 28);
        repeat (10) tick();
        lp_idle = 1'b0;
        tick();
        lp_idle = 1'b1;
        wait_valid();

        // Back to ch0, then a request for the current channel changes nothing.
        manual_req(0, 1'b1, 1'b1, 17);
        wait_valid();
        manual_req(0, 1'b0, 1'b0, 0);
        repeat (3) tick();
        check("same_ch_sel", int'(sel_o), 0);

        // Round-robin over mask 1011, two frames per channel.
        ch_mask = 4'b1011;
        fpc     = 8'd2;
        auto_en = 1'b1;
        tick();
        tick();
        check("auto_ready", int'(req_ready_o), 0);
        for (int s = 0; s < 3; s++) begin
            wait_valid();
            repeat (3) tick();
            pulse_frame();
            repeat (4) tick();
            push_exp(seq[s], cyc + 1, 17);
            pulse_frame();
        end
        wait_valid();

        // Single-channel mask with frames_per_ch=0: never switches, no error.
        ch_mask = 4'b0001;
        fpc     = 8'd0;
        for (int f = 0; f < 4; f++) begin
            repeat (3) tick();
            pulse_frame();
        end
        repeat (40) tick();
        check("solo_sel", int'(sel_o), 0);
        check("solo_valid", int'(sel_valid_o), 1);
        check("solo_err", int'(err_o), 0);

        // Current channel masked off: sticky error, advance at the next frame end.
        ch_mask = 4'b0100;
        fpc     = 8'd3;
        tick();
        tick();
        check("masked_err", int'(err_o), 1);
        exp_err = 1;
        push_exp(2, cyc + 1, 17);
        pulse_frame();
        wait_valid();

        // Manual request to ch3, then reset in the middle of WAIT_IDLE.
        auto_en = 1'b0;
        tick();
        tick();
        check("manual_ready", int'(req_ready_o), 1);
        manual_req(3, 1'b1, 1'b0, 0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_sel", int'(sel_o), 0);
        check("mid_rst_valid", int'(sel_valid_o), 0);
        check("mid_rst_busy", int'(busy_o), 1);
        check("mid_rst_err", int'(err_o), 0);
        check("mid_rst_ready", int'(req_ready_o), 0);
        repeat (3) tick();
        exp_err = 0;
        push_exp(0, -1, 0);
        rst = 1'b0;
        wait_valid();

        repeat (5) tick();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csi2_mux_sel_ctrl.md
Name: csi2_mux_sel_ctrl

Overview:
- Sequencer that drives the channel-select input of the 4-to-1 CSI-2 clock/data lane mux.
- Changes the selected camera channel only while the outgoing lanes sit in LP-11 stop state, so the downstream receiver never sees a truncated HS burst.
- Supports manual channel requests and automatic round-robin over an enable mask, switching after N frames per channel.
- Sits directly upstream of the lane mux. Its input is the lane-activity and frame-end signals from the receive-side CSI-2 monitor.

Parameters:
- NUM_CH, 4, number of mux channels; the select is log2(NUM_CH) wide.
- IDLE_MIN, 16, consecutive clk_i cycles lp_idle_i must be high before a switch.
- SETTLE_CYC, 32, cycles after a switch before the new channel is declared valid.
- FRM_CNT_W, 8, width of the frames-per-channel count.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- lp_idle_i  in  1  selected lanes in LP-11 stop state; already synchronous to clk_i.
- frame_end_i  in  1  single-cycle pulse at each frame end on the selected channel.
- auto_en_i  in  1  1 = round-robin mode, 0 = manual mode.
- ch_mask_i  in  NUM_CH  channels eligible for round-robin.
- frames_per_ch_i  in  FRM_CNT_W  frames to pass before advancing; 0 is treated as 1.
- req_valid_i  in  1  manual switch request (valid/ready handshake).
- req_ch_i  in  2  requested channel.
- req_ready_o  out  1  controller accepts a request this cycle.
- sel_o  out  2  channel select to the lane mux.
- sel_valid_o  out  1  selected channel settled; downstream may consume.
- busy_o  out  1  switch in progress.
- err_o  out  1  sticky: request for a channel that is out of range or masked off (in auto mode); cleared only by reset.

Behaviour:
- Reset values: sel_o=0, sel_valid_o=0, busy_o=1, req_ready_o=0, err_o=0, frame counter=0. Reset enters SETTLE with the settle count cleared.
- All outputs are registered.
- States:
  - RUN: sel_valid_o=1, busy_o=0, req_ready_o = ~auto_en_i.
  - WAIT_IDLE: waits for lp_idle_i high for IDLE_MIN consecutive cycles. Any low cycle restarts the count.
  - SWITCH: one cycle; sel_o <= target.
  - SETTLE: counts SETTLE_CYC cycles, then goes to RUN.
- Manual mode:
  - A request is accepted on req_valid_i & req_ready_o, and the target is latched.
  - If the target equals sel_o, the controller stays in RUN and nothing changes.
  - Otherwise it goes to WAIT_IDLE. sel_valid_o and req_ready_o drop on the cycle after acceptance.
- Auto mode:
  - The frame counter increments on each frame_end_i pulse while in RUN.
  - When the count reaches max(frames_per_ch_i, 1), the counter clears and the target becomes the next set bit of ch_mask_i above sel_o, with wrap-around.
  - If the only set bit is the current channel, or the mask is 0, there is no switch and the counter still clears.
- frame_end_i outside RUN is ignored.
- Simultaneous events:
  - frame_end_i in the same cycle as an accepted manual request cannot occur, since req_ready_o=0 in auto mode.
  - auto_en_i toggling mid-switch does not abort the switch; the new mode applies on entry to RUN.
- Error checks:
  - An out-of-range req_ch_i (≥ NUM_CH) is accepted, sets err_o, and causes no switch.
  - The current sel_o being masked off in auto mode sets err_o, and the controller advances at the next frame end.
- Switch latency from trigger to sel_o change is at least IDLE_MIN+1 cycles. sel_valid_o rises SETTLE_CYC cycles after sel_o changes.
- Reset asserted mid-operation forces the reset values immediately, regardless of state.

Test Plan:
- Reset release, lp_idle_i=1 → sel_o=0 throughout; sel_valid_o rises 32 cycles after reset deasserts; busy_o falls on the same cycle.
- Manual request ch=2 with lp_idle_i=1 steady → req accepted in 1 cycle; sel_o=2 exactly 17 cycles later; sel_valid_o=1 another 32 cycles later.
- Manual request ch=1 with lp_idle_i pulsed low at idle-count 10 → count restarts; sel_o changes only after 16 further consecutive idle cycles.
- Auto mode, mask=4'b1011, frames_per_ch=2, starting on ch0 → switches on every second frame_end_i, sequence 0→1→3→0.
- Auto mode, frames_per_ch=0, mask=4'b0001 → no switch ever; sel_o stays 0; err_o stays 0.
- Manual request ch=3 then reset asserted during WAIT_IDLE → sel_o=0, sel_valid_o=0, busy_o=1 immediately; err_o=0.
